// File: rtl/gal_tri_pkg.sv
// gal_tri_pkg: shared FSM state encoding and turnaround counter width for the tristate bank
package gal_tri_pkg;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {OFF = 2'b00, ARM = 2'b01, ON = 2'b10} state_t;
endpackage

// File: rtl/gal_tri_bit.sv
// gal_tri_bit: single-channel tristate buffer, drives A onto Y while E is high
module gal_tri_bit (
  input  logic A,
  input  logic E,
  output logic Y
);
  assign Y = E ? A : 1'bz;
endmodule

// File: rtl/tri_dff_bank.sv
// tri_dff_bank: registered tristate bank with one shared enable FSM and turnaround delay
module tri_dff_bank
  import gal_tri_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INVERT      = 0,
  parameter int TURN_CYCLES = 1
) (
  input  logic             C,
  input  logic             RN,
  input  logic             E,
  input  logic             L,
  input  logic [WIDTH-1:0] D,
  inout  wire  [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RD,
  output logic             BUSY,
  output logic             DRV
);
  localparam logic [CNT_W-1:0] TURN = CNT_W'(TURN_CYCLES);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] dq, drive;
  // next state: dropping E always releases; otherwise walk OFF -> ARM (counting down) -> ON
  always_comb begin
    state_n = !E ? OFF :
              state == OFF ? (TURN == '0 ? ON : ARM) :
              state == ARM ? (cnt == '0 ? ON : ARM) :
              state == ON  ? ON : OFF;
    cnt_n   = !E ? '0 :
              state == OFF ? (TURN == '0 ? '0 : TURN - 1'b1) :
              state == ARM && cnt != '0 ? cnt - 1'b1 : cnt;
  end
  // state, data register and pad readback; reset wins over E and L
  always_ff @(posedge C) begin
    if (!RN) begin
      state <= OFF;
      cnt   <= '0;
      dq    <= '0;
      RD    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dq    <= L ? D : dq;
      RD    <= Q;
    end
  end
  assign drive = INVERT != 0 ? ~dq : dq;
  assign BUSY  = state == ARM;
  assign DRV   = state == ON;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gal_tri_bit u_bit (.A(drive[i]), .E(DRV), .Y(Q[i]));
  end
endmodule

// File: tb/tb_tri_dff_bank.sv
// tb_tri_dff_bank: directed and random checks of two bank configurations against a run-length model
module tb_tri_dff_bank;
  logic c = 1'b0, rn, e, l, ben;
  logic [3:0] d, bval;
  wire  [3:0] q0, q1;
  logic [3:0] rd0, rd1;
  logic busy0, busy1, drv0, drv1;
  int n = 0, fails = 0;
  int run [2];
  logic [3:0] mdq [2], mrd [2];
  int tc [2] = '{2, 0};
  int inv [2] = '{0, 1};

  always #5 c = ~c;

  assign q0 = ben ? bval : 4'bzzzz;
  for (genvar i = 0; i < 4; i++) begin : g_pull
    pullup (q0[i]);
    pullup (q1[i]);
  end

  tri_dff_bank #(.WIDTH(4), .INVERT(0), .TURN_CYCLES(2)) u0 (
    .C(c), .RN(rn), .E(e), .L(l), .D(d), .Q(q0), .RD(rd0), .BUSY(busy0), .DRV(drv0));
  tri_dff_bank #(.WIDTH(4), .INVERT(1), .TURN_CYCLES(0)) u1 (
    .C(c), .RN(rn), .E(e), .L(l), .D(d), .Q(q1), .RD(rd1), .BUSY(busy1), .DRV(drv1));

  function automatic logic [3:0] pad_exp(int k);
    if (ben && k == 0) return bval;
    if (run[k] > tc[k]) return inv[k] != 0 ? ~mdq[k] : mdq[k];
    return 4'hF;
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [3:0] pre [2];
    logic [3:0] q_o [2], rd_o [2], dq_o [2];
    logic b_o [2], v_o [2];
    for (int k = 0; k < 2; k++) pre[k] = pad_exp(k);
    @(posedge c);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        run[k] = 0;
        mdq[k] = '0;
        mrd[k] = '0;
      end else begin
        mrd[k] = pre[k];
        if (l) mdq[k] = d;
        run[k] = e ? (run[k] < 64 ? run[k] + 1 : run[k]) : 0;
      end
    end
    q_o  = '{q0, q1};
    rd_o = '{rd0, rd1};
    dq_o = '{u0.dq, u1.dq};
    b_o  = '{busy0, busy1};
    v_o  = '{drv0, drv1};
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), {3'b0, b_o[k]}, {3'b0, run[k] >= 1 && run[k] <= tc[k]});
      chk($sformatf("drv%0d", k), {3'b0, v_o[k]}, {3'b0, run[k] > tc[k]});
      chk($sformatf("q%0d", k), q_o[k], pad_exp(k));
      chk($sformatf("rd%0d", k), rd_o[k], mrd[k]);
      chk($sformatf("dq%0d", k), dq_o[k], mdq[k]);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      run[k] = 0;
      mdq[k] = '0;
      mrd[k] = '0;
    end
    ben = 1'b0; bval = 4'h0;
    rn = 1'b0; e = 1'b1; l = 1'b1; d = 4'hF;
    step();
    step();
    rn = 1'b1; e = 1'b0; l = 1'b1; d = 4'hA;
    step();
    l = 1'b0; e = 1'b1;
    repeat (4) step();
    l = 1'b1; d = 4'h5;
    step();
    l = 1'b0;
    step();
    rn = 1'b0;
    step();
    rn = 1'b1; e = 1'b0;
    step();
    e = 1'b1;
    step();
    e = 1'b0;
    step();
    step();
    ben = 1'b1; bval = 4'h6;
    step();
    step();
    ben = 1'b0;
    l = 1'b1; d = 4'h3;
    step();
    l = 1'b0; e = 1'b1;
    step();
    e = 1'b0;
    step();
    for (int i = 0; i < 400; i++) begin
      rn = $urandom_range(0, 19) != 0;
      if ($urandom_range(0, 3) == 0) e = ~e;
      l = $urandom_range(0, 2) == 0;
      d = 4'($urandom);
      bval = 4'($urandom);
      ben = $urandom_range(0, 3) == 0 && run[0] <= tc[0] && !(rn && e && run[0] + 1 > tc[0]);
      step();
    end
    ben = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
